// File: rtl/mac_readout.sv
// Accumulator readout: rounds a signed fixed-point MAC sum to the output format,
// saturates it and queues it in a small FIFO. Optional macro: MAC_READOUT_RELU_EN.
module mac_readout #(
  parameter int ACCUM_WIDTH = 32,
  parameter int ACCUM_FRAC  = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_FRAC    = 10,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ACCUM_WIDTH-1:0] acc_in,
  input  logic                   acc_valid,
  input  logic                   acc_last,
  input  logic                   flush,
  input  logic                   clear_err,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_sat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   almost_full,
  output logic                   overflow_err
);

  localparam int S  = ACCUM_FRAC - OUT_FRAC;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ACCUM_WIDTH:0] RND      = {{ACCUM_WIDTH{1'b0}}, 1'b1} << (S - 1);
  localparam logic [PW-1:0]        PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0]        CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]        CNT_AF   = CW'(DEPTH - 1);

  // Returns {sat, value}: clamp the shifted sum into the signed output range.
  function automatic logic [OUT_WIDTH:0] requant(input logic [ACCUM_WIDTH:0] q);
    logic [ACCUM_WIDTH-OUT_WIDTH+1:0] hi;
    logic [OUT_WIDTH:0]               r;
    hi = q[ACCUM_WIDTH:OUT_WIDTH-1];
`ifdef MAC_READOUT_RELU_EN
    if (q[ACCUM_WIDTH]) begin
      r = {(OUT_WIDTH+1){1'b0}};
    end else if (~|hi) begin
      r = {1'b0, q[OUT_WIDTH-1:0]};
    end else begin
      r = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
`else
    if ((&hi) || (~|hi)) begin
      r = {1'b0, q[OUT_WIDTH-1:0]};
    end else if (q[ACCUM_WIDTH]) begin
      r = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      r = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
`endif
    return r;
  endfunction

  logic signed [ACCUM_WIDTH:0] sum_s;
  logic signed [ACCUM_WIDTH:0] q_s;
  logic        [OUT_WIDTH:0]   res_s;
  logic                        capture_s, pop_s, full_s, push_s, drop_s;
  logic        [OUT_WIDTH:0]   head_s;

  logic                        s1_valid_r;
  logic        [OUT_WIDTH:0]   s1_res_r;
  logic        [OUT_WIDTH:0]   mem_r [DEPTH];
  logic        [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic        [CW-1:0]        count_r;
  logic                        err_r;

  // Round half toward +inf, then requantize.
  always_comb begin
    sum_s = $signed({acc_in[ACCUM_WIDTH-1], acc_in}) + $signed(RND);
    q_s   = sum_s >>> S;
    res_s = requant(q_s);
  end

  assign capture_s = acc_valid && acc_last && !flush;
  assign full_s    = (count_r == CNT_FULL);
  assign pop_s     = out_valid && out_ready && !flush;
  assign push_s    = s1_valid_r && (!full_s || pop_s) && !flush;
  assign drop_s    = s1_valid_r && full_s && !pop_s && !flush;
  assign head_s    = mem_r[rd_ptr_r];

  // Stage-1 result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_res_r   <= {(OUT_WIDTH+1){1'b0}};
    end else begin
      s1_valid_r <= capture_s;
      if (capture_s) begin
        s1_res_r <= res_s;
      end else begin
        s1_res_r <= s1_res_r;
      end
    end
  end

  // FIFO storage; empty slots are masked at the output, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s1_res_r;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky drop flag; a same-cycle drop beats clear_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (drop_s) begin
      err_r <= 1'b1;
    end else if (clear_err) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign out_valid    = (count_r != {CW{1'b0}});
  assign out_data     = out_valid ? head_s[OUT_WIDTH-1:0] : {OUT_WIDTH{1'b0}};
  assign out_sat      = out_valid ? head_s[OUT_WIDTH] : 1'b0;
  assign almost_full  = (count_r >= CNT_AF);
  assign overflow_err = err_r;

endmodule

// File: tb/tb_mac_readout.sv
// Self-checking bench for mac_readout: directed table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_mac_readout;

  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic [31:0] acc_in;
  logic        acc_valid, acc_last, flush, clear_err, out_ready;
  logic [15:0] out_data;
  logic        out_sat, out_valid, almost_full, overflow_err;

  mac_readout dut (
    .clk(clk), .rst_n(rst_n), .acc_in(acc_in), .acc_valid(acc_valid),
    .acc_last(acc_last), .flush(flush), .clear_err(clear_err),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid),
    .out_ready(out_ready), .almost_full(almost_full), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: queued {sat, data}, pending stage result, sticky error.
  logic [16:0] m_q[$];
  logic        m_pend_v = 1'b0;
  logic [16:0] m_pend = 17'd0;
  logic        m_err = 1'b0;

  typedef struct {
    logic [31:0] acc;
    logic [15:0] data;
    logic        sat;
  } vec_t;
  vec_t tab[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-to-nearest (half up) by floor division, then clamp.
  function automatic logic [16:0] ref_val(input logic [31:0] a);
    longint v, num, q;
    v   = longint'($signed(a));
    num = v + 64'sd32;
    if (num >= 0) q = num / 64;
    else          q = -((-num + 63) / 64);
`ifdef MAC_READOUT_RELU_EN
    if (q < 0) q = 0;
`endif
    if (q > 32767)       return {1'b1, 16'h7FFF};
    else if (q < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, q[15:0]};
  endfunction

  task automatic model_edge();
    logic drop;
    drop = 1'b0;
    if (flush) begin
      m_q.delete();
      m_pend_v = 1'b0;
    end else begin
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (m_pend_v) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_pend);
        else drop = 1'b1;
      end
      m_pend_v = acc_valid && acc_last;
      if (m_pend_v) m_pend = ref_val(acc_in);
    end
    if (drop) m_err = 1'b1;
    else if (clear_err) m_err = 1'b0;
  endtask

  task automatic compare_all();
    logic [16:0] head;
    head = (m_q.size() > 0) ? m_q[0] : 17'd0;
    chk("out_valid", out_valid, m_q.size() > 0);
    chk("out_data", out_data, head[15:0]);
    chk("out_sat", out_sat, head[16]);
    chk("almost_full", almost_full, m_q.size() >= DEPTH - 1);
    chk("overflow_err", overflow_err, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic capture(input logic [31:0] a);
    acc_in = a; acc_valid = 1'b1; acc_last = 1'b1;
    step();
    acc_valid = 1'b0; acc_last = 1'b0;
  endtask

  initial begin
    int n;
    tab[0] = '{32'h00010000, 16'h0400, 1'b0};
    tab[1] = '{32'h00010020, 16'h0401, 1'b0};
    tab[2] = '{32'h0001001F, 16'h0400, 1'b0};
    tab[3] = '{32'hFFFFFFE0, 16'h0000, 1'b0};
    tab[4] = '{32'h00200000, 16'h7FFF, 1'b1};
`ifdef MAC_READOUT_RELU_EN
    tab[5] = '{32'h80000000, 16'h0000, 1'b0};
    tab[6] = '{32'hFFFF0000, 16'h0000, 1'b0};
`else
    tab[5] = '{32'h80000000, 16'h8000, 1'b1};
    tab[6] = '{32'hFFFF0000, 16'hFC00, 1'b0};
`endif

    rst_n = 1'b0; acc_in = 32'd0; acc_valid = 1'b0; acc_last = 1'b0;
    flush = 1'b0; clear_err = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_sat", out_sat, 1'b0);
    chk("rst_af", almost_full, 1'b0);
    chk("rst_err", overflow_err, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Rounding / saturation table with 2-cycle latency.
    for (int i = 0; i < 7; i++) begin
      capture(tab[i].acc);
      chk("lat1_valid", out_valid, 1'b0);
      step();
      chk("lat2_valid", out_valid, 1'b1);
      chk("tab_data", out_data, tab[i].data);
      chk("tab_sat", out_sat, tab[i].sat);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("tab_popped", out_valid, 1'b0);
    end

    // Partial sums are ignored.
    for (int i = 0; i < 8; i++) begin
      acc_in = 32'h00010000 * (i + 1); acc_valid = 1'b1; acc_last = (i == 7);
      step();
    end
    acc_valid = 1'b0; acc_last = 1'b0;
    step(); step();
    chk("filt_one", out_valid, 1'b1);
    chk("filt_data", out_data, 16'h2000);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("filt_empty", out_valid, 1'b0);

    // Overflow: five captures into a four-entry FIFO with no consumer.
    for (int k = 1; k <= 5; k++) begin
      capture(32'h00010000 * k);
      if (k == 3) chk("af_at2", almost_full, 1'b0);
      if (k == 4) chk("af_at3", almost_full, 1'b1);
    end
    step();
    chk("ovf_err", overflow_err, 1'b1);
    for (int j = 0; j < 4; j++) begin
      chk("drain_data", out_data, 16'h0400 * (j + 1));
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
    chk("drain_empty", out_valid, 1'b0);
    chk("err_sticky", overflow_err, 1'b1);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    chk("err_cleared", overflow_err, 1'b0);

    // Full FIFO with simultaneous push and pop.
    for (int k = 1; k <= 5; k++) capture(32'h00010000 * k);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("pp_err", overflow_err, 1'b0);
    chk("pp_af", almost_full, 1'b1);
    chk("pp_head", out_data, 16'h0800);
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 10) begin step(); n++; end
    out_ready = 1'b0;
    chk("pp_count", n, 4);

    // Flush with three entries queued; a same-cycle capture is ignored.
    for (int k = 1; k <= 3; k++) capture(32'h00030000 * k);
    step();
    chk("fl_af", almost_full, 1'b1);
    flush = 1'b1; acc_in = 32'h00050000; acc_valid = 1'b1; acc_last = 1'b1;
    step();
    flush = 1'b0; acc_valid = 1'b0; acc_last = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    step(); step();
    chk("fl_stale", out_valid, 1'b0);

    // Asynchronous reset with three entries queued.
    for (int k = 1; k <= 3; k++) capture(32'h00030000 * k);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_data", out_data, 16'h0000);
    chk("ar_af", almost_full, 1'b0);
    m_q.delete(); m_pend_v = 1'b0; m_err = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    capture(32'h00010000);
    chk("ar_lat1", out_valid, 1'b0);
    step();
    chk("ar_lat2", out_valid, 1'b1);
    chk("ar_data2", out_data, 16'h0400);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      logic [31:0] t;
      if ($urandom_range(0, 3) == 0) t = $urandom();
      else begin
        t = $urandom_range(0, 32'h00400000);
        if ($urandom_range(0, 1) == 1) t = -t;
      end
      acc_in    = t;
      acc_valid = ($urandom_range(0, 3) != 0);
      acc_last  = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 49) == 0);
      clear_err = ($urandom_range(0, 19) == 0);
      out_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step();
      if (c == 1000) begin
        #2 rst_n = 1'b0;
        #1 chk("rnd_rst", out_valid, 1'b0);
        m_q.delete(); m_pend_v = 1'b0; m_err = 1'b0;
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
